gbc_vram_writer: RTL and testbench

Ingest stage upstream of the 720p VGA scan-out: accepts the Game Boy Color LCD pixel stream (160x144, RGB555, one pixel per beat, valid/ready), converts each pixel to the RGB332 format the frame buffer stores, and writes it into the video SRAM at the correct linear address. A small FIFO decouples the pixel stream from the VRAM write port, which is granted only when the scan-out side is not using it. Line and frame framing is checked, and malformed frames are resynchronised without corrupting later frames.

---
 rtl/gbc_vram_writer.sv | 166 ++++++++++++++++
 tb/tb_gbc_vram_writer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gbc_vram_writer.sv
// GBC LCD pixel ingest: RGB555 -> RGB332 conversion, framing check and
// FIFO-decoupled write into the frame-buffer SRAM at y*H_PIXELS + x.
module gbc_vram_writer #(
   parameter int H_PIXELS   = 160,
   parameter int V_PIXELS   = 144,
   parameter int ADDR_WIDTH = 15,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  CLK_IN,
   input  logic                  RESET_N,
   input  logic                  PIX_VALID,
   output logic                  PIX_READY,
   input  logic [14:0]           PIX_DATA,
   input  logic                  PIX_SOF,
   input  logic                  PIX_EOL,
   output logic                  VRAM_WE,
   input  logic                  VRAM_GRANT,
   output logic [ADDR_WIDTH-1:0] VRAM_ADDR,
   output logic [7:0]            VRAM_DATA,
   output logic                  FRAME_DONE,
   output logic [7:0]            FRAME_COUNT,
   output logic [7:0]            ERR_COUNT
);

   localparam int X_W   = $clog2(H_PIXELS);
   localparam int Y_W   = $clog2(V_PIXELS);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [X_W-1:0]   X_LAST   = X_W'(H_PIXELS - 1);
   localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(V_PIXELS - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_RESYNC} state_e;

   function automatic logic [7:0] rgb555_to_332(input logic [14:0] px);
      return {px[14:12], px[9:7], px[4:3]};
   endfunction

   state_e                  state_q, state_d;
   logic [X_W-1:0]          x_q, x_d;
   logic [Y_W-1:0]          y_q, y_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
   logic                    rdy_q;
   logic [7:0]              err_q, frame_q;

   logic [ADDR_WIDTH-1:0]   addr_mem [FIFO_DEPTH];
   logic [7:0]              data_mem [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0]   last_mem;

   logic                    accept, at_line_end, at_frame_end, framing_err;
   logic                    push, push_last, pop, err_inc, head_last;
   logic [ADDR_WIDTH-1:0]   push_addr;

   assign accept       = PIX_VALID & rdy_q;
   assign at_line_end  = (x_q == X_LAST);
   assign at_frame_end = at_line_end && (y_q == Y_LAST);
   assign framing_err  = (PIX_EOL != at_line_end);

   assign pop       = (cnt_q != '0) & VRAM_GRANT;
   assign head_last = last_mem[rd_ptr_q];
   assign cnt_d     = cnt_q + CNT_W'(push) - CNT_W'(pop);

   always_ff @(posedge CLK_IN or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (accept) begin
         case (state_q)
            S_IDLE, S_RESYNC: if (PIX_SOF) state_d = S_ACTIVE;
            S_ACTIVE: begin
               if (PIX_SOF)                      state_d = S_ACTIVE;
               else if (framing_err)             state_d = S_RESYNC;
               else if (PIX_EOL && at_frame_end) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // SOF always restarts at (0,0); it only counts as an error mid-frame.
   always_comb begin
      push      = 1'b0;
      push_last = 1'b0;
      push_addr = addr_q;
      err_inc   = 1'b0;
      x_d       = x_q;
      y_d       = y_q;
      addr_d    = addr_q;
      if (accept) begin
         if (PIX_SOF) begin
            push      = 1'b1;
            push_addr = '0;
            x_d       = X_W'(1);
            y_d       = '0;
            addr_d    = ADDR_WIDTH'(1);
            err_inc   = (state_q == S_ACTIVE);
         end else if (state_q == S_ACTIVE) begin
            if (framing_err) begin
               err_inc = 1'b1;
            end else begin
               push   = 1'b1;
               addr_d = addr_q + ADDR_WIDTH'(1);
               if (PIX_EOL) begin
                  x_d       = '0;
                  y_d       = y_q + Y_W'(1);
                  push_last = at_frame_end;
               end else begin
                  x_d = x_q + X_W'(1);
               end
            end
         end
      end
   end

   // READY is registered from the next occupancy, so it is low during reset.
   always_ff @(posedge CLK_IN or negedge RESET_N) begin
      if (!RESET_N) begin
         x_q      <= '0;
         y_q      <= '0;
         addr_q   <= '0;
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         rdy_q    <= 1'b0;
         err_q    <= '0;
         frame_q  <= '0;
      end else begin
         x_q    <= x_d;
         y_q    <= y_d;
         addr_q <= addr_d;
         cnt_q  <= cnt_d;
         rdy_q  <= (cnt_d != CNT_FULL);
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
         if (pop && head_last)          frame_q <= frame_q + 8'd1;
      end
   end

   always_ff @(posedge CLK_IN) begin
      if (push) begin
         addr_mem[wr_ptr_q] <= push_addr;
         data_mem[wr_ptr_q] <= rgb555_to_332(PIX_DATA);
         last_mem[wr_ptr_q] <= push_last;
      end
   end

   // Head fields are forced to zero when empty so idle/reset outputs are defined.
   assign PIX_READY   = rdy_q;
   assign VRAM_WE     = (cnt_q != '0);
   assign VRAM_ADDR   = VRAM_WE ? addr_mem[rd_ptr_q] : '0;
   assign VRAM_DATA   = VRAM_WE ? data_mem[rd_ptr_q] : '0;
   assign FRAME_DONE  = pop & head_last;
   assign FRAME_COUNT = frame_q;
   assign ERR_COUNT   = err_q;

endmodule

// File: tb/tb_gbc_vram_writer.sv
// Self-checking bench for gbc_vram_writer: directed vectors, framing corner
// cases and randomized traffic against a position-based reference model.
module tb_gbc_vram_writer;

   localparam int H  = 160;
   localparam int V  = 144;
   localparam int NP = H * V;

   logic        CLK_IN, RESET_N, PIX_VALID, PIX_READY, PIX_SOF, PIX_EOL;
   logic [14:0] PIX_DATA;
   logic        VRAM_WE, VRAM_GRANT, FRAME_DONE;
   logic [14:0] VRAM_ADDR;
   logic [7:0]  VRAM_DATA, FRAME_COUNT, ERR_COUNT;

   gbc_vram_writer #(.H_PIXELS(H), .V_PIXELS(V), .ADDR_WIDTH(15), .FIFO_DEPTH(4)) dut (
      .CLK_IN(CLK_IN), .RESET_N(RESET_N), .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY),
      .PIX_DATA(PIX_DATA), .PIX_SOF(PIX_SOF), .PIX_EOL(PIX_EOL), .VRAM_WE(VRAM_WE),
      .VRAM_GRANT(VRAM_GRANT), .VRAM_ADDR(VRAM_ADDR), .VRAM_DATA(VRAM_DATA),
      .FRAME_DONE(FRAME_DONE), .FRAME_COUNT(FRAME_COUNT), .ERR_COUNT(ERR_COUNT)
   );

   typedef struct { int addr; int data; bit last; } exp_t;
   typedef struct { logic sof; logic eol; logic [14:0] pix; int exp_addr; int exp_data; } vec_t;

   exp_t exp_q[$];
   int   n_chk = 0, n_fail = 0;
   int   n_writes = 0, n_done = 0, done_addr = -1;
   bit   m_sync = 0;
   int   m_pos = 0, m_err = 0, m_frames = 0;
   bit   grant_rand = 0;

   initial begin
      CLK_IN = 0;
      forever #5 CLK_IN = ~CLK_IN;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached with %0d assertions evaluated", n_chk);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   function automatic int conv(input logic [14:0] d);
      int r, g, b;
      r = (int'(d) >> 10) & 31;
      g = (int'(d) >> 5) & 31;
      b = int'(d) & 31;
      return (r / 4) * 32 + (g / 4) * 4 + (b / 8);
   endfunction

   // Model: a frame is a sequence of NP positions; a line ends where pos % H == H-1.
   function automatic void model_beat(input logic [14:0] d, input logic sof, input logic eol);
      bit last_col, last;
      if (sof) begin
         if (m_sync) m_err++;
         m_sync = 1;
         exp_q.push_back('{addr: 0, data: conv(d), last: 1'b0});
         m_pos = 1;
      end else if (m_sync) begin
         last_col = ((m_pos % H) == H - 1);
         if (eol != last_col) begin
            m_err++;
            m_sync = 0;
         end else begin
            last = (m_pos == NP - 1);
            exp_q.push_back('{addr: m_pos, data: conv(d), last: last});
            m_pos++;
            if (last) begin
               m_sync = 0;
               m_frames++;
            end
         end
      end
   endfunction

   function automatic void model_clear();
      exp_q.delete();
      m_sync = 0; m_pos = 0; m_err = 0; m_frames = 0;
   endfunction

   function automatic logic [14:0] grad(input int p);
      int x, y;
      x = p % H;
      y = p / H;
      if (p == 0) return 15'h7FFF;
      if (p == 1) return 15'h0000;
      if (p == 2) return 15'h7C00;
      return 15'(((x & 31) << 10) | ((y & 31) << 5) | ((x + y) & 31));
   endfunction

   task automatic tick();
      @(posedge CLK_IN);
      #2;
   endtask

   task automatic send_beat(input logic [14:0] d, input logic sof, input logic eol);
      int guard;
      guard = 0;
      PIX_VALID = 1; PIX_DATA = d; PIX_SOF = sof; PIX_EOL = eol;
      while (PIX_READY !== 1'b1 && guard < 200) begin
         tick();
         guard++;
      end
      if (PIX_READY !== 1'b1) begin
         chk("ready_timeout", 32'(PIX_READY), 32'd1);
         PIX_VALID = 0;
         return;
      end
      model_beat(d, sof, eol);
      tick();
      PIX_VALID = 0;
   endtask

   task automatic send_range(input int p0, input int p1);
      for (int p = p0; p < p1; p++) send_beat(grad(p), p == 0, (p % H) == H - 1);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while ((exp_q.size() != 0 || VRAM_WE === 1'b1) && guard < 500) begin
         tick();
         guard++;
      end
      chk("drain_pending", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_reset();
      RESET_N = 0;
      PIX_VALID = 0;
      model_clear();
      repeat (2) tick();
      RESET_N = 1;
      tick();
   endtask

   // Scoreboard: every pop (WE & GRANT) must match the next expected write.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK_IN);
         if (RESET_N === 1'b1 && VRAM_WE === 1'b1 && VRAM_GRANT === 1'b1) begin
            n_writes++;
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_write: got write to addr %0d, required no write", VRAM_ADDR);
            end else begin
               e = exp_q.pop_front();
               chk("wr_addr", 32'(VRAM_ADDR), e.addr);
               chk("wr_data", 32'(VRAM_DATA), e.data);
               chk("wr_done", 32'(FRAME_DONE), 32'(e.last));
            end
            if (FRAME_DONE === 1'b1) begin
               n_done++;
               done_addr = int'(VRAM_ADDR);
            end
         end else if (FRAME_DONE !== 1'b0) begin
            chk("done_without_pop", 32'(FRAME_DONE), 32'd0);
         end
      end
   end

   initial begin
      forever begin
         @(posedge CLK_IN);
         #1;
         if (grant_rand) VRAM_GRANT = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      vec_t vecs[9];
      int   w0, d0, gpos;
      logic [14:0] rd;
      logic rs, re;

      vecs[0] = '{1'b1, 1'b0, 15'h7FFF, 0, 8'hFF};
      vecs[1] = '{1'b0, 1'b0, 15'h0000, 1, 8'h00};
      vecs[2] = '{1'b0, 1'b0, 15'h7C00, 2, 8'hE0};
      vecs[3] = '{1'b0, 1'b0, 15'h03E0, 3, 8'h1C};
      vecs[4] = '{1'b0, 1'b0, 15'h001F, 4, 8'h03};
      vecs[5] = '{1'b0, 1'b0, 15'h4210, 5, 8'h92};
      vecs[6] = '{1'b0, 1'b0, 15'h1CE7, 6, 8'h24};
      vecs[7] = '{1'b1, 1'b0, 15'h0C63, 0, 8'h00};
      vecs[8] = '{1'b0, 1'b0, 15'h6318, 1, 8'hDB};

      RESET_N = 0; PIX_VALID = 0; PIX_DATA = '0; PIX_SOF = 0; PIX_EOL = 0; VRAM_GRANT = 1;

      // Reset values
      #12;
      chk("rst_ready", 32'(PIX_READY), 32'd0);
      chk("rst_we", 32'(VRAM_WE), 32'd0);
      chk("rst_addr", 32'(VRAM_ADDR), 32'd0);
      chk("rst_data", 32'(VRAM_DATA), 32'd0);
      chk("rst_done", 32'(FRAME_DONE), 32'd0);
      chk("rst_fcount", 32'(FRAME_COUNT), 32'd0);
      chk("rst_ecount", 32'(ERR_COUNT), 32'd0);
      tick();
      RESET_N = 1;
      tick();
      chk("ready_after_rst", 32'(PIX_READY), 32'd1);

      // Vector table: colour conversion, one-cycle latency, SOF restart
      for (int i = 0; i < 9; i++) begin
         send_beat(vecs[i].pix, vecs[i].sof, vecs[i].eol);
         chk("vec_we", 32'(VRAM_WE), 32'd1);
         chk("vec_addr", 32'(VRAM_ADDR), vecs[i].exp_addr);
         chk("vec_data", 32'(VRAM_DATA), vecs[i].exp_data);
      end
      drain();
      chk("vec_err", 32'(ERR_COUNT), 32'd1);

      // Beats without SOF after reset are dropped silently
      do_reset();
      w0 = n_writes;
      for (int i = 0; i < 20; i++) send_beat(15'($urandom), 1'b0, 1'($urandom_range(0, 1)));
      repeat (3) tick();
      chk("nosof_writes", n_writes - w0, 0);
      chk("nosof_we", 32'(VRAM_WE), 32'd0);
      chk("nosof_err", 32'(ERR_COUNT), 32'd0);

      // Full good frame, GRANT held high
      do_reset();
      w0 = n_writes; d0 = n_done;
      send_range(0, NP);
      drain();
      chk("frame_writes", n_writes - w0, NP);
      chk("frame_done_cnt", n_done - d0, 1);
      chk("frame_done_addr", done_addr, NP - 1);
      chk("frame_count", 32'(FRAME_COUNT), 32'd1);
      chk("frame_err", 32'(ERR_COUNT), 32'd0);

      // GRANT low for 10 cycles mid-line
      do_reset();
      w0 = n_writes;
      send_range(0, 20);
      repeat (2) tick();
      VRAM_GRANT = 0;
      send_range(20, 24);
      chk("stall_ready_low", 32'(PIX_READY), 32'd0);
      PIX_VALID = 1; PIX_DATA = grad(24); PIX_SOF = 0; PIX_EOL = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("stall_ready", 32'(PIX_READY), 32'd0);
         chk("stall_head_addr", 32'(VRAM_ADDR), exp_q[0].addr);
         chk("stall_head_we", 32'(VRAM_WE), 32'd1);
      end
      VRAM_GRANT = 1;
      send_range(24, 41);
      drain();
      chk("stall_writes", n_writes - w0, 41);

      // EOL at x=100, then SOF at (50,3), then a complete frame
      do_reset();
      w0 = n_writes; d0 = n_done;
      send_range(0, 100);
      send_beat(grad(100), 1'b0, 1'b1);
      for (int i = 0; i < 30; i++) send_beat(15'($urandom), 1'b0, 1'($urandom_range(0, 1)));
      drain();
      chk("eolerr_count", 32'(ERR_COUNT), 32'd1);
      chk("eolerr_writes", n_writes - w0, 100);
      send_range(0, 3 * H + 50);
      send_range(0, NP);
      drain();
      chk("sofmid_err", 32'(ERR_COUNT), 32'd2);
      chk("sofmid_fcount", 32'(FRAME_COUNT), 32'd1);
      chk("sofmid_done", n_done - d0, 1);
      chk("sofmid_writes", n_writes - w0, 100 + 3 * H + 50 + NP);

      // 300 framing errors saturate ERR_COUNT
      do_reset();
      for (int i = 0; i < 300; i++) begin
         send_beat(15'($urandom), 1'b1, 1'b0);
         send_beat(15'($urandom), 1'b0, 1'b1);
      end
      drain();
      chk("err_sat", 32'(ERR_COUNT), 32'd255);
      chk("err_sat_model", 32'(ERR_COUNT), 32'((m_err > 255) ? 255 : m_err));

      // Asynchronous reset with three entries pending
      do_reset();
      VRAM_GRANT = 0;
      send_range(0, 3);
      chk("prerst_we", 32'(VRAM_WE), 32'd1);
      #3;
      RESET_N = 0;
      #1;
      chk("async_we", 32'(VRAM_WE), 32'd0);
      chk("async_addr", 32'(VRAM_ADDR), 32'd0);
      chk("async_ready", 32'(PIX_READY), 32'd0);
      model_clear();
      w0 = n_writes;
      tick();
      tick();
      RESET_N = 1;
      VRAM_GRANT = 1;
      repeat (10) tick();
      chk("postrst_writes", n_writes - w0, 0);
      for (int i = 0; i < 5; i++) send_beat(15'($urandom), 1'b0, 1'b0);
      repeat (3) tick();
      chk("postrst_idle_drop", n_writes - w0, 0);
      send_beat(15'h7FFF, 1'b1, 1'b0);
      drain();
      chk("postrst_sof_write", n_writes - w0, 1);

      // Randomized traffic with injected framing faults and random GRANT
      do_reset();
      grant_rand = 1;
      gpos = -1;
      for (int i = 0; i < 4000; i++) begin
         rs = (gpos < 0) || ($urandom_range(0, 199) == 0);
         if (rs) gpos = 0;
         re = ((gpos % H) == H - 1);
         if ($urandom_range(0, 149) == 0) re = ~re;
         rd = 15'($urandom);
         send_beat(rd, rs, re);
         gpos++;
         if ($urandom_range(0, 7) == 0) tick();
      end
      grant_rand = 0;
      @(posedge CLK_IN);
      #2;
      VRAM_GRANT = 1;
      drain();
      chk("rand_err", 32'(ERR_COUNT), 32'((m_err > 255) ? 255 : m_err));
      chk("rand_fcount", 32'(FRAME_COUNT), 32'(m_frames % 256));
      chk("rand_we_idle", 32'(VRAM_WE), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
